// File: rtl/riscv_bitops_unit.sv
// riscv_bitops_unit: byte-serial popcount / bit-reverse unit for OPCODE_MYBITOPS.
// Define RISCV_BITOPS_FAST_EN to compute the whole result at capture (IDLE->DONE).
module riscv_bitops_unit #(
  parameter int BIT_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [BIT_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_i,
  input  logic                    ex_ready_i,
  input  logic                    kill_i,
  output logic [31:0]             result_o,
  output logic                    ready_o,
  output logic                    busy_o
);

  localparam logic [BIT_OP_WIDTH-1:0] BIT_OP_BITCOUNT = BIT_OP_WIDTH'(2'b00);
  localparam logic [BIT_OP_WIDTH-1:0] BIT_OP_REVERSE  = BIT_OP_WIDTH'(2'b01);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [31:0]             r_opnd;
  logic [BIT_OP_WIDTH-1:0] r_op;
  logic [31:0]             r_acc;
  logic [31:0]             r_result;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, b[i]};
    return c;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // One byte step: popcount accumulates in a 6-bit sum, reverse mirrors byte k to slot 3-k.
  function automatic logic [31:0] step_byte(input logic [BIT_OP_WIDTH-1:0] op,
                                            input logic [31:0] acc,
                                            input logic [7:0]  b,
                                            input logic [1:0]  k);
    logic [31:0] r;
    case (op)
      BIT_OP_BITCOUNT: r = {26'd0, acc[5:0] + {2'd0, popcount8(b)}};
      BIT_OP_REVERSE: begin
        r = acc;
        r[{2'd3 - k, 3'b000} +: 8] = bitrev8(b);
      end
      default:         r = 32'd0;
    endcase
    return r;
  endfunction

`ifdef RISCV_BITOPS_FAST_EN
  function automatic logic [31:0] full_result(input logic [BIT_OP_WIDTH-1:0] op,
                                              input logic [31:0] opnd);
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < 4; k++) acc = step_byte(op, acc, opnd[8*k +: 8], 2'(k));
    return acc;
  endfunction

  logic [31:0] w_fast_result;
  assign w_fast_result = full_result(operator_i, operand_i);
`else
  logic [1:0]  r_cnt;
  logic [31:0] w_acc_step;
  assign w_acc_step = step_byte(r_op, r_acc, r_opnd[{r_cnt, 3'b000} +: 8], r_cnt);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; kill overrides capture and completion.
  always_comb begin
    w_state_next = r_state;
    if (kill_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
`ifdef RISCV_BITOPS_FAST_EN
            w_state_next = S_DONE;
`else
            w_state_next = S_BUSY;
`endif
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_BUSY: begin
`ifdef RISCV_BITOPS_FAST_EN
          w_state_next = S_DONE;
`else
          if (r_cnt == 2'd3) w_state_next = S_DONE;
          else               w_state_next = S_BUSY;
`endif
        end
        S_DONE: begin
          if (ex_ready_i) w_state_next = S_IDLE;
          else            w_state_next = S_DONE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Handshake outputs; ready_o is the only combinational output path.
  always_comb begin
    ready_o = 1'b0;
    busy_o  = (r_state != S_IDLE);
    if (kill_i) begin
      ready_o = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:  ready_o = ~enable_i;
        S_DONE:  ready_o = 1'b1;
        default: ready_o = 1'b0;
      endcase
    end
  end

  // Datapath: capture, byte iteration, and a result register that is nonzero only in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd   <= 32'd0;
      r_op     <= '0;
      r_acc    <= 32'd0;
      r_result <= 32'd0;
`ifndef RISCV_BITOPS_FAST_EN
      r_cnt    <= 2'd0;
`endif
    end else if (kill_i) begin
      r_acc    <= 32'd0;
      r_result <= 32'd0;
`ifndef RISCV_BITOPS_FAST_EN
      r_cnt    <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_opnd <= operand_i;
            r_op   <= operator_i;
`ifdef RISCV_BITOPS_FAST_EN
            r_acc    <= w_fast_result;
            r_result <= w_fast_result;
`else
            r_acc <= 32'd0;
            r_cnt <= 2'd0;
`endif
          end
        end
        S_BUSY: begin
`ifndef RISCV_BITOPS_FAST_EN
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_result <= w_acc_step;
`endif
        end
        S_DONE: begin
          if (ex_ready_i) r_result <= 32'd0;
        end
        default: r_result <= 32'd0;
      endcase
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_riscv_bitops_unit.sv
// Directed self-checking bench for riscv_bitops_unit (both build variants).
module tb_riscv_bitops_unit;

`ifdef RISCV_BITOPS_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 5;
`endif
  localparam int KILL_CYC = (LAT > 2) ? 2 : 1;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic [1:0]  operator_i;
  logic [31:0] operand_i;
  logic        ex_ready_i;
  logic        kill_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks;
  int errors;

  riscv_bitops_unit #(.BIT_OP_WIDTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .operator_i (operator_i),
    .operand_i  (operand_i),
    .ex_ready_i (ex_ready_i),
    .kill_i     (kill_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation starting now (cycle 0) and hold the result for `stall` extra cycles.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] opnd,
                       input logic [31:0] exp, input int stall);
    enable_i   = 1'b1;
    operator_i = op;
    operand_i  = opnd;
    ex_ready_i = (stall == 0);
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      chk({tag, " ready_low"}, {31'd0, ready_o}, 32'd0);
      chk({tag, " busy"}, {31'd0, busy_o}, (c == 0) ? 32'd0 : 32'd1);
      next_cycle();
      operand_i = ~opnd;
    end
    for (int s = 0; s <= stall; s++) begin
      ex_ready_i = (s == stall);
      @(negedge clk);
      chk({tag, " done_ready"}, {31'd0, ready_o}, 32'd1);
      chk({tag, " result"}, result_o, exp);
      chk({tag, " done_busy"}, {31'd0, busy_o}, 32'd1);
      next_cycle();
    end
    enable_i   = 1'b0;
    ex_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, " idle_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, " idle_ready"}, {31'd0, ready_o}, 32'd1);
    next_cycle();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    enable_i   = 1'b0;
    operator_i = 2'b00;
    operand_i  = 32'd0;
    ex_ready_i = 1'b1;
    kill_i     = 1'b0;

    // Reset state
    #2;
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst result", result_o, 32'd0);
    chk("rst ready_noen", {31'd0, ready_o}, 32'd1);
    enable_i = 1'b1;
    #1;
    chk("rst ready_en", {31'd0, ready_o}, 32'd0);
    enable_i = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    do_op("bc_ffff", 2'b00, 32'hFFFF_FFFF, 32'h0000_0020, 0);
    do_op("rev_1234", 2'b01, 32'h1234_5678, 32'h1E6A_2C48, 0);
    do_op("rev_0001", 2'b01, 32'h0000_0001, 32'h8000_0000, 0);
    do_op("bc_zero", 2'b00, 32'h0000_0000, 32'h0000_0000, 0);
    do_op("bc_stall", 2'b00, 32'h8000_0001, 32'h0000_0002, 4);
    do_op("reserved", 2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 0);

    // Kill mid-operation, followed immediately by a new capture
    enable_i   = 1'b1;
    operator_i = 2'b01;
    operand_i  = 32'h1234_5678;
    ex_ready_i = 1'b0;
    for (int c = 0; c < KILL_CYC; c++) next_cycle();
    kill_i = 1'b1;
    @(negedge clk);
    chk("kill ready", {31'd0, ready_o}, 32'd1);
    next_cycle();
    kill_i = 1'b0;
    do_op("after_kill", 2'b00, 32'h0F0F_0F0F, 32'h0000_0010, 0);

    // Asynchronous reset in cycle 3 of an operation
    enable_i   = 1'b1;
    operator_i = 2'b00;
    operand_i  = 32'hFFFF_FFFF;
    ex_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) next_cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy_o}, 32'd0);
    chk("midrst result", result_o, 32'd0);
    chk("midrst ready_en", {31'd0, ready_o}, 32'd0);
    enable_i = 1'b0;
    #1;
    chk("midrst ready_noen", {31'd0, ready_o}, 32'd1);
    next_cycle();
    chk("midrst hold_busy", {31'd0, busy_o}, 32'd0);
    rst_n      = 1'b1;
    ex_ready_i = 1'b1;
    next_cycle();
    do_op("rev_00ff", 2'b01, 32'h0000_00FF, 32'hFF00_0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
